// File: rtl/endpoint_flit_tx.sv
// Endpoint injection transmitter: turns packet requests into HEAD/BODY/TAIL
// flits for switch port 0 under per-VC credit flow control.
package endpoint_flit_tx_pkg;
  localparam int FLIT_VC_W   = 1;
  localparam int FLIT_NODE_W = 3;
  localparam int FLIT_DATA_W = 32;

  typedef enum logic [1:0] {
    KIND_HEAD = 2'd0,
    KIND_BODY = 2'd1,
    KIND_TAIL = 2'd2
  } flit_kind_t;

  typedef struct packed {
    logic [FLIT_VC_W-1:0]   vc;
    logic [FLIT_NODE_W-1:0] dest;
    flit_kind_t             kind;
    logic [FLIT_DATA_W-1:0] payload;
  } flit_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HEAD = 2'd1,
    ST_BODY = 2'd2
  } state_t;
endpackage

// Handshakes: a transfer happens on a rising edge where valid & ready are both
// high; ready never depends combinationally on the matching valid.
module endpoint_flit_tx
  import endpoint_flit_tx_pkg::*;
#(
  parameter int NUM_VCS     = 2,
  parameter int BUFFER_SIZE = 8,
  parameter int TOTAL_NODES = 4,
  parameter int NODE        = 1,
  parameter int MAX_LEN     = 15,
  parameter int DATA_W      = 32,
  localparam int VC_W   = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1,
  localparam int NODE_W = $clog2(TOTAL_NODES + 1),
  localparam int LEN_W  = $clog2(MAX_LEN + 1),
  localparam int CRED_W = $clog2(BUFFER_SIZE + 1)
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [NODE_W-1:0]  req_dest,
  input  logic [VC_W-1:0]    req_vc,
  input  logic [LEN_W-1:0]   req_len,
  input  logic [DATA_W-1:0]  wdata,
  input  logic               wdata_valid,
  output logic               wdata_ready,
  output flit_t              out_flit,
  output logic               data_ready_out,
  input  logic [NUM_VCS-1:0] credit_granted,
  output logic               busy,
  output logic               credit_err,
  output state_t             fsm_state
);

  localparam logic [NODE_W-1:0] NODE_ID  = NODE[NODE_W-1:0];
  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(BUFFER_SIZE);

  state_t             state;
  logic [NODE_W-1:0]  dest_q;
  logic [VC_W-1:0]    vc_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   cnt_q;
  logic [CRED_W-1:0]  credit [NUM_VCS];

  logic               has_credit;
  logic               send_head;
  logic               send_body;
  logic [LEN_W-1:0]   cnt_next;
  logic [DATA_W-1:0]  head_payload;
  logic [NUM_VCS-1:0] take;

  // Send decisions look only at the registered credit count.
  always_comb begin
    has_credit   = (credit[vc_q] != '0);
    req_ready    = (state == ST_IDLE);
    wdata_ready  = (state == ST_BODY) && has_credit;
    send_head    = (state == ST_HEAD) && has_credit;
    send_body    = wdata_valid && wdata_ready;
    cnt_next     = cnt_q + 1'b1;
    head_payload = '0;
    head_payload[NODE_W+LEN_W-1:0] = {NODE_ID, len_q};
    take = '0;
    for (int v = 0; v < NUM_VCS; v++) begin
      take[v] = (send_head || send_body) && (vc_q == VC_W'(v));
    end
  end

  assign busy      = (state != ST_IDLE);
  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (n_rst) begin
      state          <= ST_IDLE;
      dest_q         <= '0;
      vc_q           <= '0;
      len_q          <= '0;
      cnt_q          <= '0;
      out_flit       <= '0;
      data_ready_out <= 1'b0;
      credit_err     <= 1'b0;
      for (int v = 0; v < NUM_VCS; v++) credit[v] <= CRED_MAX;
    end else begin
      data_ready_out <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            dest_q <= req_dest;
            vc_q   <= req_vc;
            len_q  <= req_len;
            cnt_q  <= '0;
            state  <= ST_HEAD;
          end
        end
        ST_HEAD: begin
          if (send_head) begin
            // A zero-length packet is a single flit that is both head and tail.
            out_flit <= '{vc: vc_q, dest: dest_q,
                          kind: (len_q == '0) ? KIND_TAIL : KIND_HEAD,
                          payload: head_payload};
            data_ready_out <= 1'b1;
            state <= (len_q == '0) ? ST_IDLE : ST_BODY;
          end
        end
        ST_BODY: begin
          if (send_body) begin
            cnt_q    <= cnt_next;
            out_flit <= '{vc: vc_q, dest: dest_q,
                          kind: (cnt_next == len_q) ? KIND_TAIL : KIND_BODY,
                          payload: wdata};
            data_ready_out <= 1'b1;
            if (cnt_next == len_q) state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // Simultaneous send and return on one VC cancel out.
      for (int v = 0; v < NUM_VCS; v++) begin
        if (credit_granted[v] && !take[v]) begin
          if (credit[v] == CRED_MAX) credit_err <= 1'b1;
          else                       credit[v]  <= credit[v] + 1'b1;
        end else if (take[v] && !credit_granted[v]) begin
          credit[v] <= credit[v] - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_endpoint_flit_tx.sv
// Directed bench for endpoint_flit_tx: drivers push expected flits into a
// queue, a negedge monitor pops and compares every flit the DUT emits.
module tb_endpoint_flit_tx;
  import endpoint_flit_tx_pkg::*;

  localparam int FW     = $bits(flit_t);
  localparam int BUDGET = 50;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_dest;
  logic [0:0]  req_vc;
  logic [3:0]  req_len;
  logic [31:0] wdata;
  logic        wdata_valid;
  logic        wdata_ready;
  flit_t       out_flit;
  logic        data_ready_out;
  logic [1:0]  credit_granted;
  logic        busy;
  logic        credit_err;
  state_t      fsm_state;

  logic [FW-1:0] exp_q[$];
  int            flit_cyc[$];
  int            cyc = 0;
  int            checks = 0;
  int            failures = 0;

  endpoint_flit_tx dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_dest       (req_dest),
    .req_vc         (req_vc),
    .req_len        (req_len),
    .wdata          (wdata),
    .wdata_valid    (wdata_valid),
    .wdata_ready    (wdata_ready),
    .out_flit       (out_flit),
    .data_ready_out (data_ready_out),
    .credit_granted (credit_granted),
    .busy           (busy),
    .credit_err     (credit_err),
    .fsm_state      (fsm_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic flit_t make_flit(input logic vc, input logic [2:0] dest,
                                      input flit_kind_t kind, input logic [31:0] pl);
    flit_t f;
    f.vc = vc;
    f.dest = dest;
    f.kind = kind;
    f.payload = pl;
    return f;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (data_ready_out === 1'b1) begin
      flit_cyc.push_back(cyc);
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_flit: got %0h expected none", out_flit);
      end else begin
        logic [FW-1:0] e;
        e = exp_q.pop_front();
        if (out_flit !== e) begin
          failures++;
          $display("FAIL flit: got %0h expected %0h", out_flit, e);
        end
      end
    end
  end

  // driver tasks: called and returning at a falling edge
  task automatic send_req(input logic [2:0] dest, input logic vc, input logic [3:0] len,
                          input logic [31:0] head_pl);
    int n = 0;
    req_valid = 1'b1;
    req_dest  = dest;
    req_vc    = vc;
    req_len   = len;
    exp_q.push_back(make_flit(vc, dest, (len == 0) ? KIND_TAIL : KIND_HEAD, head_pl));
    while (!req_ready && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    if (n == BUDGET) begin
      checks++;
      failures++;
      $display("FAIL req_timeout: got req_ready=0 expected 1");
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drive_word(input logic vc, input logic [2:0] dest, input logic [31:0] w,
                            input bit tail);
    int n = 0;
    wdata       = w;
    wdata_valid = 1'b1;
    exp_q.push_back(make_flit(vc, dest, tail ? KIND_TAIL : KIND_BODY, w));
    while (!wdata_ready && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    if (n == BUDGET) begin
      checks++;
      failures++;
      $display("FAIL wdata_timeout: got wdata_ready=0 expected 1");
    end
    @(posedge clk);
    @(negedge clk);
    wdata_valid = 1'b0;
  endtask

  task automatic pulse_credit(input int v);
    credit_granted[v] = 1'b1;
    @(negedge clk);
    credit_granted[v] = 1'b0;
  endtask

  initial begin
    n_rst = 1'b1;
    req_valid = 1'b0;
    req_dest = '0;
    req_vc = '0;
    req_len = '0;
    wdata = '0;
    wdata_valid = 1'b0;
    credit_granted = '0;
    repeat (3) @(negedge clk);

    check("rst_credit0", 64'(dut.credit[0]), 64'd8);
    check("rst_credit1", 64'(dut.credit[1]), 64'd8);
    check("rst_valid", 64'(data_ready_out), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_credit_err", 64'(credit_err), 64'd0);
    n_rst = 1'b0;
    @(negedge clk);

    // dest 3, vc 0, len 2: head payload {1,2} = 0x12
    flit_cyc.delete();
    send_req(3'd3, 1'b0, 4'd2, 32'h0000_0012);
    drive_word(1'b0, 3'd3, 32'hAAAA_0001, 1'b0);
    drive_word(1'b0, 3'd3, 32'hBBBB_0002, 1'b1);
    @(negedge clk);
    check("p1_flit_count", 64'(flit_cyc.size()), 64'd3);
    if (flit_cyc.size() == 3) check("p1_back_to_back", 64'(flit_cyc[2] - flit_cyc[0]), 64'd2);
    check("p1_credit0", 64'(dut.credit[0]), 64'd5);
    check("p1_idle", 64'(busy), 64'd0);

    // vc 1, len 10 with no returns: head + 7 bodies then stall
    send_req(3'd2, 1'b1, 4'd10, 32'h0000_001A);
    for (int i = 1; i <= 7; i++) drive_word(1'b1, 3'd2, 32'hC000_0000 + 32'(i), 1'b0);
    wdata = 32'hC000_0008;
    wdata_valid = 1'b1;
    exp_q.push_back(make_flit(1'b1, 3'd2, KIND_BODY, 32'hC000_0008));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_wdata_ready", 64'(wdata_ready), 64'd0);
      check("stall_no_flit", 64'(data_ready_out), 64'd0);
    end
    check("stall_credit1", 64'(dut.credit[1]), 64'd0);
    pulse_credit(1);
    check("one_credit_ready", 64'(wdata_ready), 64'd1);
    @(negedge clk);
    wdata_valid = 1'b0;
    check("one_credit_flit", 64'(data_ready_out), 64'd1);
    check("one_credit_used", 64'(dut.credit[1]), 64'd0);
    check("one_credit_stall", 64'(wdata_ready), 64'd0);
    for (int i = 9; i <= 10; i++) begin
      pulse_credit(1);
      drive_word(1'b1, 3'd2, 32'hC000_0000 + 32'(i), i == 10);
    end
    @(negedge clk);
    check("p2_idle", 64'(busy), 64'd0);

    // len 0 on vc 0 with a same-cycle credit return: count stays 5
    send_req(3'd1, 1'b0, 4'd0, 32'h0000_0010);
    credit_granted[0] = 1'b1;
    @(negedge clk);
    credit_granted[0] = 1'b0;
    check("same_cycle_credit0", 64'(dut.credit[0]), 64'd5);
    check("len0_idle", 64'(busy), 64'd0);
    @(negedge clk);

    // len 0 alone consumes exactly one credit
    send_req(3'd2, 1'b0, 4'd0, 32'h0000_0010);
    @(negedge clk);
    @(negedge clk);
    check("len0_credit0", 64'(dut.credit[0]), 64'd4);
    check("len0_idle2", 64'(busy), 64'd0);

    // refill vc 1 to the limit, then overflow it
    repeat (8) pulse_credit(1);
    check("refill_credit1", 64'(dut.credit[1]), 64'd8);
    check("refill_no_err", 64'(credit_err), 64'd0);
    pulse_credit(1);
    check("overflow_saturate", 64'(dut.credit[1]), 64'd8);
    check("overflow_err", 64'(credit_err), 64'd1);

    // reset after the 2nd body flit of a len 5 packet
    send_req(3'd3, 1'b0, 4'd5, 32'h0000_0015);
    drive_word(1'b0, 3'd3, 32'hD000_0001, 1'b0);
    drive_word(1'b0, 3'd3, 32'hD000_0002, 1'b0);
    n_rst = 1'b1;
    wdata = 32'hD000_0003;
    wdata_valid = 1'b1;
    @(negedge clk);
    n_rst = 1'b0;
    wdata_valid = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_no_flit", 64'(data_ready_out), 64'd0);
    check("abort_req_ready", 64'(req_ready), 64'd1);
    check("abort_credit0", 64'(dut.credit[0]), 64'd8);
    check("abort_credit1", 64'(dut.credit[1]), 64'd8);
    check("abort_err_cleared", 64'(credit_err), 64'd0);
    repeat (5) @(negedge clk);
    check("all_flits_seen", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/endpoint_flit_tx.md
Name: endpoint_flit_tx

Overview:
- Endpoint-side transmitter that injects packets into one switch input port (local port 0).
- Packetizes local requests into HEAD/BODY/TAIL flits and drives `out_flit` / `data_ready_out` into the switch's `in` / `data_ready_in`.
- Obeys credit-based flow control using one credit counter per VC, replenished by the switch's `credit_granted` pulses.
- It is the sending counterpart to the switch's receive and credit-return path. It replaces the bench-driven stimulus on each node's injection port.

Parameters:
- NUM_VCS, 2, number of virtual channels; VC_W = max(1, clog2(NUM_VCS)).
- BUFFER_SIZE, 8, switch input buffer depth per VC; initial and maximum credit count.
- TOTAL_NODES, 4, node count; NODE_W = clog2(TOTAL_NODES + 1).
- NODE, 1, this endpoint's node ID, placed in the head flit as the source.
- MAX_LEN, 15, maximum body-flit count per packet; LEN_W = clog2(MAX_LEN + 1).
- DATA_W, 32, payload width of flit_t.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- n_rst  in  1  synchronous, active-high reset (reset asserted when 1).
- req_valid  in  1  packet request valid.
- req_ready  out  1  request accepted when req_valid & req_ready.
- req_dest  in  NODE_W  destination node.
- req_vc  in  VC_W  VC for the whole packet.
- req_len  in  LEN_W  body flit count, 0..MAX_LEN.
- wdata  in  DATA_W  body payload word.
- wdata_valid  in  1  body word valid.
- wdata_ready  out  1  body word consumed when wdata_valid & wdata_ready.
- out_flit  out  flit_t  flit to switch; fields used: vc, dest, kind (HEAD/BODY/TAIL), payload.
- data_ready_out  out  1  out_flit valid; one cycle per flit.
- credit_granted  in  NUM_VCS  one-cycle credit return per VC.
- busy  out  1  packet in progress (state != IDLE).
- credit_err  out  1  sticky: a credit was returned while the counter was already at BUFFER_SIZE.

Behaviour:
- Reset (n_rst = 1 at a clock edge): state = IDLE; every credit[v] = BUFFER_SIZE; data_ready_out = 0; out_flit = 0; credit_err = 0; busy = 0.
- Reset mid-packet aborts the packet with no TAIL emitted. Credits are restored to BUFFER_SIZE.
- FSM states: IDLE, HEAD, BODY.
- IDLE:
  - req_ready = 1.
  - On accept, latch dest, vc, len; clear the body counter; go to HEAD.
- HEAD:
  - req_ready = 0.
  - If credit[vc] > 0, register a head flit: kind = HEAD (TAIL when len = 0), dest, vc, payload = {NODE, len} zero-extended.
  - On send, decrement credit. If len = 0 go to IDLE, else go to BODY.
  - If credit[vc] = 0, stall in HEAD.
- BODY:
  - wdata_ready = (credit[vc] > 0), combinational.
  - On a wdata handshake, register a BODY flit with payload = wdata and increment the body counter.
  - The flit carrying the len-th word has kind = TAIL; after it, go to IDLE.
  - wdata_valid low inserts bubbles: data_ready_out = 0 that cycle and no credit is used.
- Output timing:
  - out_flit and data_ready_out are registered; a flit appears the cycle after its send decision.
  - Request accept at cycle N gives the head flit at N+2 at the earliest (decision at N+1).
  - Back-to-back packets reach at most 1 flit/cycle within a packet. There is one IDLE cycle between packets.
- Credit rules:
  - The send decision uses the registered credit value; there is no same-cycle credit bypass.
  - Send and credit return on the same VC in the same cycle leave the count unchanged.
  - Credit return on a different VC is independent.
  - Credit return at BUFFER_SIZE: the count saturates and credit_err sets, staying set until reset.
  - Credit width = clog2(BUFFER_SIZE + 1); the count never goes below 0.
- Latched request fields are stable for the whole packet. req_* inputs are ignored outside IDLE.

Test Plan:
- Reset, then check outputs → credit[0] = credit[1] = 8, data_ready_out = 0, req_ready = 1, busy = 0, credit_err = 0.
- req dest = 3, vc = 0, len = 2; words A, B held valid → three consecutive flits: HEAD{dest 3, payload {1, 2}}, BODY A, TAIL B. credit[0] = 5, then IDLE.
- vc = 1, len = 10, no credits returned → HEAD plus 7 BODY flits, then wdata_ready = 0 stall. One credit_granted[1] pulse → exactly one more BODY flit the cycle after the next decision.
- Credit return on vc 0 in the same cycle as a vc 0 send → credit[0] unchanged. A pulse on vc 1 while idle with credit[1] = 8 → stays 8 and credit_err = 1.
- len = 0 request → single flit with kind = TAIL carrying the head fields, then IDLE. Only one credit consumed.
- n_rst asserted after the 2nd body flit of a len = 5 packet → next cycle state IDLE, no further flits, credits back to 8, req_ready = 1.
